// File: rtl/score_bcd_display.sv
// Converts a 17-bit binary score to six BCD digits with an iterative double-dabble
// engine and drives six active-low 7-segment digits with leading-zero blanking and blinking.
module score_bcd_display #(
  parameter int unsigned BLINK_PERIOD = 25000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [16:0] score,
  input  logic        game_over,
  output logic [23:0] bcd,
  output logic        bcd_valid,
  output logic        busy,
  output logic [6:0]  hex0,
  output logic [6:0]  hex1,
  output logic [6:0]  hex2,
  output logic [6:0]  hex3,
  output logic [6:0]  hex4,
  output logic [6:0]  hex5
);

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_e;

  localparam int unsigned CNT_W = (BLINK_PERIOD > 1) ? $clog2(BLINK_PERIOD) : 1;
  localparam logic [6:0]  SEG_BLANK = 7'b1111111;

  state_e             state_q, state_d;
  logic [16:0]        bin_sr_q, cap_q, last_conv_q;
  logic [23:0]        bcd_sr_q, bcd_adj, bcd_q;
  logic [4:0]         bit_cnt_q;
  logic               bcd_valid_q;
  logic [CNT_W-1:0]   blink_cnt_q;
  logic               blink_phase_q;
  logic [5:0][6:0]    hex_q, hex_d;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = SEG_BLANK;
    endcase
  endfunction

  // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // NOTE: a default assignment up front keeps combinational blocks from inferring latches.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (score != last_conv_q) state_d = CONV;
      CONV:    if (bit_cnt_q == 5'd16) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q != IDLE);
  end

  // Add-3 correction applied to every nibble before each shift step.
  always_comb begin
    bcd_adj = bcd_sr_q;
    for (int i = 0; i < 6; i++) begin
      if (bcd_sr_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_sr_q[4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      bin_sr_q    <= '0;
      bcd_sr_q    <= '0;
      bit_cnt_q   <= '0;
      cap_q       <= '0;
      last_conv_q <= '0;
      bcd_q       <= '0;
      bcd_valid_q <= 1'b0;
    end else begin
      bcd_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (score != last_conv_q) begin
            bin_sr_q  <= score;
            cap_q     <= score;
            bcd_sr_q  <= '0;
            bit_cnt_q <= '0;
          end
        end
        CONV: begin
          {bcd_sr_q, bin_sr_q} <= {bcd_adj[22:0], bin_sr_q, 1'b0};
          bit_cnt_q            <= bit_cnt_q + 5'd1;
        end
        DONE: begin
          bcd_q       <= bcd_sr_q;
          last_conv_q <= cap_q;
          bcd_valid_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst || !game_over) begin
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
    end else if (blink_cnt_q == CNT_W'(BLINK_PERIOD - 1)) begin
      blink_cnt_q   <= '0;
      blink_phase_q <= ~blink_phase_q;
    end else begin
      blink_cnt_q   <= blink_cnt_q + 1'b1;
    end
  end

  // Walk from the top digit down; a digit stays blank while it and all higher digits are zero.
  always_comb begin
    logic       lead;
    logic [3:0] digit;
    lead  = 1'b1;
    hex_d = '0;
    for (int k = 5; k >= 0; k--) begin
      digit    = bcd_q[4*k +: 4];
      lead     = lead && (digit == 4'd0) && (k != 0);
      hex_d[k] = (lead || (game_over && blink_phase_q)) ? SEG_BLANK : seg7(digit);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      hex_q    <= {6{SEG_BLANK}};
      hex_q[0] <= 7'b1000000;
    end else begin
      hex_q    <= hex_d;
    end
  end

  assign bcd       = bcd_q;
  assign bcd_valid = bcd_valid_q;
  assign hex0      = hex_q[0];
  assign hex1      = hex_q[1];
  assign hex2      = hex_q[2];
  assign hex3      = hex_q[3];
  assign hex4      = hex_q[4];
  assign hex5      = hex_q[5];

endmodule

// File: tb/tb_score_bcd_display.sv
// Scoreboard bench for score_bcd_display: expected conversions are queued at stimulus time
// and a negedge monitor pops one per bcd_valid pulse; display values come from a decimal model.
module tb_score_bcd_display;

  localparam int BP = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [16:0] score;
  logic        game_over;
  logic [23:0] bcd;
  logic        bcd_valid;
  logic        busy;
  logic [6:0]  hex0, hex1, hex2, hex3, hex4, hex5;

  score_bcd_display #(.BLINK_PERIOD(BP)) dut (
    .clk(clk), .rst(rst), .score(score), .game_over(game_over),
    .bcd(bcd), .bcd_valid(bcd_valid), .busy(busy),
    .hex0(hex0), .hex1(hex1), .hex2(hex2), .hex3(hex3), .hex4(hex4), .hex5(hex5)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int exp_q[$];
  int model_last = 0;

  always @(posedge clk) cyc <= cyc + 1;

  wire [41:0] hex_all = {hex5, hex4, hex3, hex2, hex1, hex0};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: seg_of = 7'b1000000;  1: seg_of = 7'b1111001;
      2: seg_of = 7'b0100100;  3: seg_of = 7'b0110000;
      4: seg_of = 7'b0011001;  5: seg_of = 7'b0010010;
      6: seg_of = 7'b0000010;  7: seg_of = 7'b1111000;
      8: seg_of = 7'b0000000;  9: seg_of = 7'b0010000;
      default: seg_of = 7'b1111111;
    endcase
  endfunction

  function automatic logic [23:0] bcd_model(input int v);
    int p = 1;
    bcd_model = '0;
    for (int k = 0; k < 6; k++) begin
      bcd_model[4*k +: 4] = 4'((v / p) % 10);
      p = p * 10;
    end
  endfunction

  // Digit k is lit when it is the ones digit or the value reaches 10^k.
  function automatic logic [41:0] hex_model(input int v, input bit blank_all);
    int p = 1;
    hex_model = '0;
    for (int k = 0; k < 6; k++) begin
      if (blank_all || (k != 0 && v < p)) hex_model[7*k +: 7] = 7'b1111111;
      else                                 hex_model[7*k +: 7] = seg_of((v / p) % 10);
      p = p * 10;
    end
  endfunction

  always @(negedge clk) begin
    int e;
    if (bcd_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_pulse: got bcd %0h with no conversion pending", bcd);
      end else begin
        e = exp_q.pop_front();
        check("bcd", {40'd0, bcd}, {40'd0, bcd_model(e)});
      end
    end
  end

  task automatic wait_pulse(input int start, output int lat);
    bit found = 1'b0;
    lat = -1;
    for (int i = 0; i < 60 && !found; i++) begin
      @(negedge clk);
      if (bcd_valid === 1'b1) begin
        found = 1'b1;
        lat   = cyc - start;
      end
    end
    if (!found) begin
      n_checks++;
      n_fail++;
      $display("FAIL pulse_timeout: no bcd_valid within 60 cycles");
    end
  endtask

  task automatic convert(input int v);
    int start, lat;
    score = 17'(v);
    if (v != model_last) exp_q.push_back(v);
    model_last = v;
    start = cyc;
    wait_pulse(start, lat);
    check("latency", 64'(lat), 64'd19);
    @(negedge clk);
    check("hex", {22'd0, hex_all}, {22'd0, hex_model(v, 1'b0)});
    check("busy_after", {63'd0, busy}, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int v, start, lat, lat2;
    int ranges[6] = '{9, 99, 999, 9999, 99999, 131071};
    bit busy_seen;

    rst = 1'b0; score = '0; game_over = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_bcd", {40'd0, bcd}, 64'd0);
    check("rst_valid", {63'd0, bcd_valid}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_hex", {22'd0, hex_all}, {22'd0, hex_model(0, 1'b0)});

    rst = 1'b1;
    busy_seen = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (busy !== 1'b0) busy_seen = 1'b1;
    end
    check("idle_busy", {63'd0, busy_seen}, 64'd0);
    check("idle_bcd", {40'd0, bcd}, 64'd0);
    check("idle_hex", {22'd0, hex_all}, {22'd0, hex_model(0, 1'b0)});

    convert(123);
    convert(131071);

    for (int i = 0; i < 10; i++) begin
      v = int'($urandom_range(0, ranges[i % 6]));
      if (v == model_last) v = (v + 1) % 131072;
      convert(v);
    end

    // A change three cycles into a conversion is picked up right after DONE.
    score = 17'd5;
    exp_q.push_back(5);
    start = cyc;
    repeat (3) @(negedge clk);
    score = 17'd7;
    exp_q.push_back(7);
    model_last = 7;
    wait_pulse(start, lat);
    check("b2b_lat1", 64'(lat), 64'd19);
    start = cyc;
    wait_pulse(start, lat2);
    check("b2b_lat2", 64'(lat2), 64'd19);
    @(negedge clk);
    check("b2b_hex", {22'd0, hex_all}, {22'd0, hex_model(7, 1'b0)});

    // Blink: the display goes dark for BP edges, starting BP+1 edges after game_over rises.
    convert(42);
    game_over = 1'b1;
    for (int n = 1; n <= 16; n++) begin
      @(negedge clk);
      check("blink", {22'd0, hex_all}, {22'd0, hex_model(42, ((n - 1) / BP) % 2 == 1)});
    end
    game_over = 1'b0;
    @(negedge clk);
    check("blink_drop", {22'd0, hex_all}, {22'd0, hex_model(42, 1'b0)});
    game_over = 1'b1;
    for (int n = 1; n <= BP + 1; n++) begin
      @(negedge clk);
      check("blink_restart", {22'd0, hex_all}, {22'd0, hex_model(42, n > BP)});
    end
    game_over = 1'b0;
    @(negedge clk);

    // Reset lands on CONV step 10; the one queued 999 must come from the fresh conversion.
    score = 17'd999;
    exp_q.push_back(999);
    model_last = 999;
    repeat (10) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("abort_bcd", {40'd0, bcd}, 64'd0);
    check("abort_busy", {63'd0, busy}, 64'd0);
    check("abort_valid", {63'd0, bcd_valid}, 64'd0);
    check("abort_hex", {22'd0, hex_all}, {22'd0, hex_model(0, 1'b0)});
    rst = 1'b1;
    start = cyc;
    wait_pulse(start, lat);
    check("abort_relat", 64'(lat), 64'd19);
    @(negedge clk);
    check("abort_rehex", {22'd0, hex_all}, {22'd0, hex_model(999, 1'b0)});

    repeat (3) @(negedge clk);
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/score_bcd_display.md
# score_bcd_display

Consumer of the game's 17-bit binary `score`. It converts the score to six BCD digits with an iterative shift-add-3 (double-dabble) engine and drives the six board 7-segment digits HEX5..HEX0. Leading digits are blanked, and the whole field blinks while `game_over` is high. It sits beside `guitar_hero_display` at top level, on the reading side of its `score`/`game_over` outputs.

## Interface
- `BLINK_PERIOD`, default 25000000: clock cycles per blink half-period. Must be ≥ 1.
- `clk`  in  1  system clock; the only clock in the block.
- `rst`  in  1  reset, synchronous, active-low. Asserted when 0.
- `score`  in  17  unsigned binary score, sampled only in IDLE.
- `game_over`  in  1  level; enables blinking while high.
- `bcd`  out  24  last completed conversion, 6 digits × 4 bits; [3:0] is the ones digit.
- `bcd_valid`  out  1  one-cycle pulse when `bcd` updates.
- `busy`  out  1  high while a conversion is in flight (CONV or DONE).
- `hex0`..`hex5`  out  7 each  segments, active-low, bit order {g,f,e,d,c,b,a}; `hex0` is the ones digit.

## Operation
- State machine: IDLE, CONV, DONE.
  - IDLE: if `score != last_conv`, capture `score` into `bin_sr` (17 bits), clear `bcd_sr` (24 bits), set `bit_cnt = 0`, and go to CONV. Otherwise stay in IDLE.
  - CONV: each cycle, first add 3 to every nibble of `bcd_sr` that is ≥ 5. Then shift {`bcd_sr`, `bin_sr`} left by 1. Increment `bit_cnt`. When `bit_cnt == 16` (the 17th step), go to DONE.
  - DONE: `bcd <= bcd_sr`, `last_conv <= captured value`, pulse `bcd_valid`, return to IDLE.
- `score` changes during CONV or DONE are ignored. IDLE re-compares on the next cycle and starts a fresh conversion, so the last stable value is always converted eventually.
- Arithmetic is unsigned; no negative display. A `score` of 17'h1FFFF (an underflow from 0) displays 131071. The maximum value 131071 fits in 6 digits, so no overflow is possible.
- Segment codes (active-low, {g..a}):
  - 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000, 4 = 0011001
  - 5 = 0010010, 6 = 0000010, 7 = 1111000, 8 = 0000000, 9 = 0010000
  - blank = 1111111
- Leading-zero blanking: digit k (k ≥ 1) is blank when digit k and every higher digit are 0. `hex0` is never blanked by this rule.
- Blink: `blink_cnt` counts 0..BLINK_PERIOD-1 while `game_over` = 1. At BLINK_PERIOD-1 it wraps to 0 and toggles `blink_phase`. While `game_over` = 0, `blink_cnt` = 0 and `blink_phase` = 0. When `game_over` = 1 and `blink_phase` = 1, all six hex outputs are blank. Blinking does not stall conversion.
- Hex outputs are registered from `bcd`, blanking and `blink_phase`.

## Timing
- Reset (rst = 0 at a clock edge) sets:
  - state = IDLE, `bcd` = 0, `last_conv` = 0
  - `bcd_valid` = 0, `busy` = 0
  - `blink_cnt` = 0, `blink_phase` = 0
  - `hex0` = 1000000, `hex1`..`hex5` = 1111111
- Reset mid-conversion aborts the conversion. `bcd` returns to 0 and no `bcd_valid` pulse occurs.
- Latency, with edge E0 being the IDLE edge that captures the score:
  - CONV steps occur on edges E1..E17.
  - DONE occurs at E18: `bcd` and `bcd_valid` are set and visible after E18.
  - `hex*` reflect the new `bcd` after E19.
- `busy` is high after E0 through E18 and low after E18.
- Back-to-back conversions: when `score` differs again at the IDLE edge after DONE, the next conversion starts there. Minimum period between `bcd_valid` pulses is 19 cycles.
- If `score` equals `last_conv`, no conversion runs and `busy` stays low.

## Test plan
- Reset with `score` = 0, then hold 30 cycles → `busy` never high, `bcd` = 0, `hex0` = 1000000, `hex1`..`hex5` blank.
- `score` 0 → 123 → `bcd_valid` pulses exactly 18 edges after capture, `bcd` = 24'h000123. One edge later: `hex2`/`hex1`/`hex0` = 1111001/0100100/0110000, `hex3`..`hex5` blank.
- `score` = 17'h1FFFF → `bcd` = 24'h131071, all six digits lit, no blanking.
- `score` = 5, then change to 7 three cycles after capture → first pulse shows `bcd` = 24'h000005. The next IDLE edge starts a new conversion, and a second pulse 19 cycles after the first shows `bcd` = 24'h000007.
- BLINK_PERIOD = 4, `score` = 42 converted, `game_over` raised → hex outputs alternate 4 cycles lit / 4 cycles all blank. Dropping `game_over` restores lit display next cycle with `blink_cnt` = 0.
- `rst` = 0 at CONV step 10 of a 999 conversion → `bcd` = 0, `busy` = 0, no `bcd_valid`. After release, with `score` still 999, a fresh conversion yields `bcd` = 24'h000999.
